// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : EX operand bypass select, load-use / multi-cycle stall detection
//            and occupancy tracking for a single MUL/DIV unit.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
  parameter int ADDR_W  = 5,
  parameter int NSRC    = 2,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NSRC*ADDR_W-1:0]   ID_SRCaddr_i,
  input  logic [NSRC-1:0]          ID_SRCuse_i,
  input  logic                     ID_MulIssue_i,
  input  logic [NSRC*ADDR_W-1:0]   ID_EX_SRCaddr_i,
  input  logic [ADDR_W-1:0]        ID_EX_RDaddr_i,
  input  logic                     ID_EX_MemRead_i,
  input  logic                     ID_EX_MulIssue_i,
  input  logic                     EX_MEM_RegWrite_i,
  input  logic [ADDR_W-1:0]        EX_MEM_RDaddr_i,
  input  logic                     MEM_WB_RegWrite_i,
  input  logic [ADDR_W-1:0]        MEM_WB_RDaddr_i,
  output logic [2*NSRC-1:0]        Forward_o,
  output logic                     Stall_o,
  output logic                     MulBusy_o,
  output logic                     MulDone_o,
  output logic [ADDR_W-1:0]        MulRD_o
);

  localparam logic [ADDR_W-1:0] c_zeroAddr = '0;
  localparam logic [CNT_W-1:0]  c_issueCnt = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]  c_lastCnt  = CNT_W'(1);

  localparam logic [1:0] c_selRegFile = 2'b00;
  localparam logic [1:0] c_selMemWb   = 2'b01;
  localparam logic [1:0] c_selExMem   = 2'b10;
  localparam logic [1:0] c_selMul     = 2'b11;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_mulRd;

  logic              w_issue;
  logic              w_lastCycle;
  logic [ADDR_W-1:0] w_pendRd;
  logic              w_mulInFlight;
  logic [NSRC-1:0]   w_loadUseHit;
  logic [NSRC-1:0]   w_mulDepHit;
  logic              w_loadUseStall;
  logic              w_depStall;
  logic              w_structStall;

  // An issue while busy cannot legally happen (structural stall); it is ignored.
  assign w_issue     = ID_EX_MulIssue_i && !r_busy;
  assign w_lastCycle = r_busy && (r_cnt == c_lastCnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mulRd <= '0;
    end else begin
      if (w_issue) begin
        r_busy  <= 1'b1;
        r_cnt   <= c_issueCnt;
        r_mulRd <= ID_EX_RDaddr_i;
      end else if (r_busy) begin
        r_cnt <= r_cnt - c_lastCnt;
        if (w_lastCycle) begin
          r_busy <= 1'b0;
        end
      end

      // A new issue in the done cycle keeps done asserted one more cycle.
      if (w_lastCycle) begin
        r_done <= 1'b1;
      end else if (!w_issue) begin
        r_done <= 1'b0;
      end
    end
  end

  // Destination the ID stage must wait for: the running op, else the one issuing now.
  assign w_pendRd      = r_busy ? r_mulRd : ID_EX_RDaddr_i;
  assign w_mulInFlight = r_busy || ID_EX_MulIssue_i;

  generate
    for (genvar k = 0; k < NSRC; k++) begin : g_operand
      logic [ADDR_W-1:0] w_exSrc;
      logic [ADDR_W-1:0] w_idSrc;
      logic              w_exNonZero;

      assign w_exSrc     = ID_EX_SRCaddr_i[k*ADDR_W +: ADDR_W];
      assign w_idSrc     = ID_SRCaddr_i[k*ADDR_W +: ADDR_W];
      assign w_exNonZero = (w_exSrc != c_zeroAddr);

      assign Forward_o[2*k +: 2] =
        (w_exNonZero && r_done && (r_mulRd == w_exSrc))                     ? c_selMul   :
        (w_exNonZero && EX_MEM_RegWrite_i && (EX_MEM_RDaddr_i == w_exSrc)) ? c_selExMem :
        (w_exNonZero && MEM_WB_RegWrite_i && (MEM_WB_RDaddr_i == w_exSrc)) ? c_selMemWb :
                                                                              c_selRegFile;

      assign w_loadUseHit[k] = ID_SRCuse_i[k] && (w_idSrc == ID_EX_RDaddr_i);
      assign w_mulDepHit[k]  = ID_SRCuse_i[k] && (w_idSrc == w_pendRd);
    end
  endgenerate

  assign w_loadUseStall = ID_EX_MemRead_i && (ID_EX_RDaddr_i != c_zeroAddr) && (|w_loadUseHit);
  assign w_depStall     = w_mulInFlight && (w_pendRd != c_zeroAddr) && (|w_mulDepHit);
  assign w_structStall  = ID_MulIssue_i && w_mulInFlight;

  assign Stall_o   = w_loadUseStall || w_depStall || w_structStall;
  assign MulBusy_o = r_busy;
  assign MulDone_o = r_done;
  assign MulRD_o   = r_mulRd;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// Testbench for fwd_hazard_unit: directed scenarios plus randomized traffic,
// checked against a cycle-indexed reference model of the multi-cycle unit.
module tb_fwd_hazard_unit;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int LAT = 4;
  localparam int AW2 = 6;
  localparam int NS2 = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS*AW-1:0] idSrc;
  logic [NS-1:0]    idUse;
  logic             idMul;
  logic [NS*AW-1:0] exSrc;
  logic [AW-1:0]    exRd;
  logic             exMemRead;
  logic             exMulIssue;
  logic             memW;
  logic [AW-1:0]    memRd;
  logic             wbW;
  logic [AW-1:0]    wbRd;
  logic [2*NS-1:0]  fwd;
  logic             stall;
  logic             mulBusy;
  logic             mulDone;
  logic [AW-1:0]    mulRdOut;

  logic [NS2*AW2-1:0] d2ExSrc;
  logic               d2MemW;
  logic [AW2-1:0]     d2MemRd;
  logic               d2WbW;
  logic [AW2-1:0]     d2WbRd;
  logic [2*NS2-1:0]   d2Fwd;
  logic               d2Stall;
  logic               d2Busy;
  logic               d2Done;
  logic [AW2-1:0]     d2MulRd;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.ADDR_W(AW), .NSRC(NS), .MUL_LAT(LAT), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_SRCaddr_i(idSrc), .ID_SRCuse_i(idUse), .ID_MulIssue_i(idMul),
    .ID_EX_SRCaddr_i(exSrc), .ID_EX_RDaddr_i(exRd),
    .ID_EX_MemRead_i(exMemRead), .ID_EX_MulIssue_i(exMulIssue),
    .EX_MEM_RegWrite_i(memW), .EX_MEM_RDaddr_i(memRd),
    .MEM_WB_RegWrite_i(wbW), .MEM_WB_RDaddr_i(wbRd),
    .Forward_o(fwd), .Stall_o(stall), .MulBusy_o(mulBusy),
    .MulDone_o(mulDone), .MulRD_o(mulRdOut)
  );

  fwd_hazard_unit #(.ADDR_W(AW2), .NSRC(NS2), .MUL_LAT(LAT), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .ID_SRCaddr_i({(NS2*AW2){1'b0}}), .ID_SRCuse_i({NS2{1'b0}}), .ID_MulIssue_i(1'b0),
    .ID_EX_SRCaddr_i(d2ExSrc), .ID_EX_RDaddr_i({AW2{1'b0}}),
    .ID_EX_MemRead_i(1'b0), .ID_EX_MulIssue_i(1'b0),
    .EX_MEM_RegWrite_i(d2MemW), .EX_MEM_RDaddr_i(d2MemRd),
    .MEM_WB_RegWrite_i(d2WbW), .MEM_WB_RDaddr_i(d2WbRd),
    .Forward_o(d2Fwd), .Stall_o(d2Stall), .MulBusy_o(d2Busy),
    .MulDone_o(d2Done), .MulRD_o(d2MulRd)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Model of the multi-cycle unit: when the last op issued and where it writes.
  int cyc       = 0;
  int mIssue    = -1000;
  int mDoneExt  = -1000;
  int mRd       = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit mBusy();
    return (cyc > mIssue) && (cyc < mIssue + LAT);
  endfunction

  function automatic bit mDone();
    return (cyc == mIssue + LAT) || (cyc == mDoneExt);
  endfunction

  function automatic int fwdSel(int s, bit dn, int mr, bit mw, int mrd, bit ww, int wrd);
    if (s == 0) return 0;
    if (dn && mr == s) return 3;
    if (mw && mrd == s) return 2;
    if (ww && wrd == s) return 1;
    return 0;
  endfunction

  task automatic sample();
    bit busyE, doneE, lu, dep, st;
    int pend, s;
    @(negedge clk);
    busyE = mBusy();
    doneE = mDone();
    checkVal("mulBusy", mulBusy, busyE);
    checkVal("mulDone", mulDone, doneE);
    checkVal("mulRd", mulRdOut, mRd);
    checkVal("illegalIssue", exMulIssue && mulBusy, 0);
    for (int k = 0; k < NS; k++)
      checkVal("forward", fwd[2*k +: 2],
               fwdSel(exSrc[k*AW +: AW], doneE, mRd, memW, memRd, wbW, wbRd));
    lu = 0; dep = 0;
    pend = busyE ? mRd : int'(exRd);
    for (int k = 0; k < NS; k++) begin
      s = idSrc[k*AW +: AW];
      if (idUse[k]) begin
        if (exMemRead && exRd != 0 && s == exRd) lu = 1;
        if ((busyE || exMulIssue) && pend != 0 && s == pend) dep = 1;
      end
    end
    st = idMul && (busyE || exMulIssue);
    checkVal("stall", stall, lu || dep || st);
    for (int k = 0; k < NS2; k++)
      checkVal("forwardWide", d2Fwd[2*k +: 2],
               fwdSel(d2ExSrc[k*AW2 +: AW2], 0, 0, d2MemW, d2MemRd, d2WbW, d2WbRd));
  endtask

  task automatic advance();
    bit busyE, doneE;
    busyE = mBusy();
    doneE = mDone();
    if (rst) begin
      mIssue = -1000; mDoneExt = -1000; mRd = 0;
    end else if (exMulIssue && !busyE) begin
      if (doneE) mDoneExt = cyc + 1;
      mIssue = cyc;
      mRd    = exRd;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; idSrc = '0; idUse = '0; idMul = 0; exSrc = '0; exRd = '0;
    exMemRead = 0; exMulIssue = 0; memW = 0; memRd = '0; wbW = 0; wbRd = '0;
    d2ExSrc = '0; d2MemW = 0; d2MemRd = '0; d2WbW = 0; d2WbRd = '0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    advance();
    rst = 0;
    sample();
    checkVal("resetBusy", mulBusy, 0);
    checkVal("resetDone", mulDone, 0);
    checkVal("resetRd", mulRdOut, 0);
    advance();

    // Bypass priority EX/MEM over MEM/WB, then MEM/WB alone, then r0.
    exSrc[0 +: AW] = 3; memW = 1; memRd = 3; wbW = 1; wbRd = 3;
    sample(); checkVal("fwdExMem", fwd[1:0], 2'b10); advance();
    memW = 0;
    sample(); checkVal("fwdMemWb", fwd[1:0], 2'b01); advance();
    exSrc[0 +: AW] = 0; memW = 1; memRd = 0; wbRd = 0;
    sample(); checkVal("fwdZero", fwd[1:0], 2'b00); advance();
    idle();

    // Load-use on operand 1, with and without the use bit.
    exMemRead = 1; exRd = 5; idSrc[AW +: AW] = 5; idUse = 2'b10;
    sample(); checkVal("loadUse", stall, 1); advance();
    idUse = 2'b01;
    sample(); checkVal("loadUseUnused", stall, 0); advance();
    idle();

    // Multi-cycle op to r7 with a dependent reader in ID.
    exMulIssue = 1; exRd = 7; idSrc[0 +: AW] = 7; idUse = 2'b01;
    sample(); checkVal("depStallIssue", stall, 1); advance();
    exMulIssue = 0; exRd = 0;
    for (int i = 1; i <= 3; i++) begin
      sample();
      checkVal("mulBusyRun", mulBusy, 1);
      checkVal("depStallBusy", stall, 1);
      advance();
    end
    exSrc[0 +: AW] = 7; memW = 1; memRd = 7;
    sample();
    checkVal("mulDoneRun", mulDone, 1);
    checkVal("depStallDone", stall, 0);
    checkVal("fwdMul", fwd[1:0], 2'b11);
    advance();
    idle();

    // Structural stall, then back-to-back issue in the done cycle.
    exMulIssue = 1; exRd = 9; idMul = 1;
    sample(); checkVal("structIssue", stall, 1); advance();
    exMulIssue = 0;
    for (int i = 1; i <= 3; i++) begin
      sample(); checkVal("structBusy", stall, 1); advance();
    end
    idMul = 0; exMulIssue = 1; exRd = 10;
    sample(); checkVal("doneBeforeReissue", mulDone, 1); advance();
    exMulIssue = 0; exRd = 0;
    sample();
    checkVal("doneAfterReissue", mulDone, 1);
    checkVal("busyAfterReissue", mulBusy, 1);
    checkVal("rdAfterReissue", mulRdOut, 10);
    advance();
    for (int i = 0; i < 5; i++) begin sample(); advance(); end

    // Reset in the middle of an op abandons it.
    exMulIssue = 1; exRd = 7;
    sample(); advance();
    exMulIssue = 0; exRd = 0; idSrc[0 +: AW] = 7; idUse = 2'b01;
    sample(); advance();
    rst = 1;
    sample(); advance();
    rst = 0;
    sample();
    checkVal("rstBusy", mulBusy, 0);
    checkVal("rstDone", mulDone, 0);
    checkVal("rstRd", mulRdOut, 0);
    checkVal("rstStall", stall, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      sample(); checkVal("noLateDone", mulDone, 0); advance();
    end
    idle();

    // Wide build: operand 2 matches EX/MEM r40.
    d2ExSrc[2*AW2 +: AW2] = 40; d2ExSrc[0 +: AW2] = 1; d2ExSrc[AW2 +: AW2] = 2;
    d2MemW = 1; d2MemRd = 40;
    sample();
    checkVal("wideFwd2", d2Fwd[5:4], 2'b10);
    checkVal("wideFwdOthers", d2Fwd[3:0], 4'b0000);
    advance();

    // Randomized traffic on small register numbers to provoke hits.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < NS; k++) begin
        idSrc[k*AW +: AW] = AW'($urandom_range(0, 7));
        exSrc[k*AW +: AW] = AW'($urandom_range(0, 7));
      end
      for (int k = 0; k < NS2; k++) d2ExSrc[k*AW2 +: AW2] = AW2'($urandom_range(38, 42));
      idUse      = NS'($urandom);
      idMul      = ($urandom_range(0, 3) == 0);
      exRd       = AW'($urandom_range(0, 7));
      exMemRead  = ($urandom_range(0, 3) == 0);
      exMulIssue = !mBusy() && ($urandom_range(0, 2) == 0);
      memW       = $urandom_range(0, 1);
      memRd      = AW'($urandom_range(0, 7));
      wbW        = $urandom_range(0, 1);
      wbRd       = AW'($urandom_range(0, 7));
      d2MemW     = $urandom_range(0, 1);
      d2MemRd    = AW2'($urandom_range(38, 42));
      d2WbW      = $urandom_range(0, 1);
      d2WbRd     = AW2'($urandom_range(38, 42));
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
